// File: rtl/aw_write_scheduler_if.sv
// AW request/forward and W-steering signal bundle for aw_write_scheduler.
// The master modport is the scheduler's view; the slave modport is the surrounding fabric's view.
interface aw_write_scheduler_if #(
    parameter int ADDR_W = 32
);
    logic [1:0]        awvalid_m;
    logic [ADDR_W-1:0] awaddr_m1;
    logic [ADDR_W-1:0] awaddr_m2;
    logic [1:0]        awready_m;
    logic [5:0]        awvalid_s;
    logic [ADDR_W-1:0] awaddr_s;
    logic [5:0]        awready_s;
    logic              w_done;
    logic              w_sel_valid;
    logic              w_sel_master;
    logic [2:0]        w_sel_slave;

    modport master (
        input  awvalid_m, awaddr_m1, awaddr_m2, awready_s, w_done,
        output awready_m, awvalid_s, awaddr_s, w_sel_valid, w_sel_master, w_sel_slave
    );

    modport slave (
        output awvalid_m, awaddr_m1, awaddr_m2, awready_s, w_done,
        input  awready_m, awvalid_s, awaddr_s, w_sel_valid, w_sel_master, w_sel_slave
    );
endinterface

// File: rtl/aw_write_scheduler.sv
// AW arbiter (M1/M2 -> S0..S5/default) plus an order FIFO that steers the W mux one burst at a time.
// Define AW_SCHED_FIXED_PRIO_EN for fixed priority (M1 wins); default build is round-robin.
module aw_write_scheduler #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    aw_write_scheduler_if.master bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_ADDR = 1'b1;
    localparam logic [2:0] DEC_DEFAULT = 3'd7;

    function automatic logic [2:0] decode(input logic [ADDR_W-1:0] a);
        logic [2:0] d;
        d = DEC_DEFAULT;
        if (a <= ADDR_W'(32'h0000_3FFF))
            d = 3'd0;
        else if (a >= ADDR_W'(32'h0001_0000) && a <= ADDR_W'(32'h0001_FFFF))
            d = 3'd1;
        else if (a >= ADDR_W'(32'h0002_0000) && a <= ADDR_W'(32'h0002_FFFF))
            d = 3'd2;
        else if (a >= ADDR_W'(32'h1000_0000) && a <= ADDR_W'(32'h1000_03FF))
            d = 3'd3;
        else if (a >= ADDR_W'(32'h1001_0000) && a <= ADDR_W'(32'h1001_03FF))
            d = 3'd4;
        else if (a >= ADDR_W'(32'h2000_0000) && a <= ADDR_W'(32'h201F_FFFF))
            d = 3'd5;
        return d;
    endfunction

    logic [0:0]        state_reg, state_next;
    logic              grant_reg, grant_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [2:0]        dec_reg, dec_next;
    logic [PTR_W-1:0]  rd_ptr_reg, wr_ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [3:0]        fifo_mem [DEPTH];
    logic [3:0]        head;
    logic [5:0]        hit;
    logic              addr_phase, fifo_full, fifo_nonempty, pick, hs, pop;

    assign addr_phase    = (state_reg == ST_ADDR);
    assign fifo_full     = (count_reg == CNT_W'(DEPTH));
    assign fifo_nonempty = (count_reg != '0);

`ifdef AW_SCHED_FIXED_PRIO_EN
    assign pick = ~bus.awvalid_m[0];
`else
    // last_reg holds the master served most recently; it loses the next tie.
    logic last_reg;
    assign pick = (&bus.awvalid_m) ? ~last_reg : bus.awvalid_m[1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            last_reg <= 1'b1;
        else if (hs)
            last_reg <= grant_reg;
    end
`endif

    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_slave
            assign bus.awvalid_s[gi] = addr_phase && (dec_reg == 3'(gi));
            assign hit[gi]           = bus.awvalid_s[gi] & bus.awready_s[gi];
        end
    endgenerate

    // The default slave accepts immediately, so its handshake needs no awready_s.
    assign hs            = addr_phase && ((dec_reg == DEC_DEFAULT) || (|hit));
    assign bus.awready_m = {hs & grant_reg, hs & ~grant_reg};
    assign bus.awaddr_s  = addr_phase ? addr_reg : '0;
    assign pop           = bus.w_done && fifo_nonempty;

    always_comb begin
        state_next = state_reg;
        grant_next = grant_reg;
        addr_next  = addr_reg;
        dec_next   = dec_reg;
        case (state_reg)
            ST_IDLE: begin
                if ((|bus.awvalid_m) && !fifo_full) begin
                    grant_next = pick;
                    addr_next  = pick ? bus.awaddr_m2 : bus.awaddr_m1;
                    dec_next   = decode(addr_next);
                    state_next = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (hs)
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= ST_IDLE;
            grant_reg  <= 1'b0;
            addr_reg   <= '0;
            dec_reg    <= '0;
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            state_reg <= state_next;
            grant_reg <= grant_next;
            addr_reg  <= addr_next;
            dec_reg   <= dec_next;
            if (hs)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({hs, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (hs)
            fifo_mem[wr_ptr_reg] <= {grant_reg, dec_reg};
    end

    // Stale entries are masked so the W selector reads zero whenever the queue is empty.
    assign head             = fifo_mem[rd_ptr_reg];
    assign bus.w_sel_valid  = fifo_nonempty;
    assign bus.w_sel_master = fifo_nonempty & head[3];
    assign bus.w_sel_slave  = fifo_nonempty ? head[2:0] : 3'd0;
endmodule

// File: tb/tb_aw_write_scheduler.sv
// Randomized bench for aw_write_scheduler with a transaction-level model (grant + in-order queue)
// plus directed sequences that pin the model with literal expectations.
module tb_aw_write_scheduler;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    aw_write_scheduler_if #(.ADDR_W(32)) bus();

    aw_write_scheduler #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // stimulus state: a request stays up with a fixed address until it is accepted
    logic [1:0]  req;
    logic [31:0] addr [2];
    logic [5:0]  rdy_s;
    logic        wd;

    // model state
    logic [3:0]  q[$];
    bit          have_grant;
    bit          gm;
    bit          last_served;
    logic [2:0]  exp_dec;
    bit          exp_hs;

    int unsigned lo [6] = '{32'h0000_0000, 32'h0001_0000, 32'h0002_0000,
                            32'h1000_0000, 32'h1001_0000, 32'h2000_0000};
    int unsigned hi [6] = '{32'h0000_3FFF, 32'h0001_FFFF, 32'h0002_FFFF,
                            32'h1000_03FF, 32'h1001_03FF, 32'h201F_FFFF};

    function automatic logic [2:0] model_dec(input logic [31:0] a);
        for (int i = 0; i < 6; i++)
            if (a >= lo[i] && a <= hi[i]) return 3'(i);
        return 3'd7;
    endfunction

    function automatic logic [31:0] rand_addr();
        int unsigned r, k;
        logic [31:0] dflt [6];
        dflt = '{32'h0000_4000, 32'h0000_FFFF, 32'h0003_0000,
                 32'h1000_0400, 32'h3000_0000, 32'hFFFF_FFFC};
        r = $urandom_range(0, 6);
        k = $urandom_range(0, 3);
        if (r == 6) return dflt[$urandom_range(0, 5)];
        case (k)
            0:       return lo[r];
            1:       return hi[r];
            2:       return hi[r] + 1;
            default: return lo[r] + ($urandom % (hi[r] - lo[r] + 1));
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        have_grant  = 0;
        gm          = 0;
        last_served = 1;
        exp_hs      = 0;
        exp_dec     = 3'd7;
    endtask

    task automatic apply_inputs();
        bus.awvalid_m = req;
        bus.awaddr_m1 = addr[0];
        bus.awaddr_m2 = addr[1];
        bus.awready_s = rdy_s;
        bus.w_done    = wd;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_awvalid_s"}, 32'(bus.awvalid_s), 32'd0);
        check({tag, "_awready_m"}, 32'(bus.awready_m), 32'd0);
        check({tag, "_awaddr_s"}, bus.awaddr_s, 32'd0);
        check({tag, "_w_sel_valid"}, 32'(bus.w_sel_valid), 32'd0);
        check({tag, "_w_sel_master"}, 32'(bus.w_sel_master), 32'd0);
        check({tag, "_w_sel_slave"}, 32'(bus.w_sel_slave), 32'd0);
    endtask

    // Drive this cycle's inputs at the falling edge, then compare outputs against the model.
    task automatic drive_check();
        logic [5:0]  exp_vs;
        logic [1:0]  exp_rm;
        logic [31:0] exp_as;
        @(negedge clk);
        apply_inputs();
        #1;
        exp_vs = '0;
        exp_rm = '0;
        exp_as = '0;
        exp_hs = 0;
        if (have_grant) begin
            exp_dec = model_dec(addr[gm]);
            exp_hs  = (exp_dec == 3'd7) ? 1'b1 : rdy_s[exp_dec];
            exp_as  = addr[gm];
            if (exp_dec != 3'd7) exp_vs = 6'(1 << exp_dec);
            if (exp_hs) exp_rm = gm ? 2'b10 : 2'b01;
        end
        check("awvalid_s", 32'(bus.awvalid_s), 32'(exp_vs));
        check("awready_m", 32'(bus.awready_m), 32'(exp_rm));
        check("awaddr_s", bus.awaddr_s, exp_as);
        check("w_sel_valid", 32'(bus.w_sel_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            check("w_sel_master", 32'(bus.w_sel_master), 32'(q[0][3]));
            check("w_sel_slave", 32'(bus.w_sel_slave), 32'(q[0][2:0]));
        end
    endtask

    // Advance the model across the rising edge.
    task automatic commit();
        int pre;
        @(posedge clk);
        pre = q.size();
        if (wd && pre != 0) void'(q.pop_front());
        if (have_grant) begin
            if (exp_hs) begin
                q.push_back({gm, exp_dec});
                last_served = gm;
                have_grant  = 0;
                req[gm]     = 1'b0;
            end
        end else if (req != 2'b00 && pre < DEPTH) begin
`ifdef AW_SCHED_FIXED_PRIO_EN
            gm = req[0] ? 1'b0 : 1'b1;
`else
            if (req[0] && req[1]) gm = !last_served;
            else                  gm = req[1];
`endif
            have_grant = 1;
        end
    endtask

    task automatic step();
        drive_check();
        commit();
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b0;
        #1 check_all_zero("midreset");
        model_reset();
        repeat (2) @(negedge clk);
        check_all_zero("inreset");
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    initial begin
        int unsigned p_req, p_done;
        model_reset();
        req     = 2'b11;
        addr[0] = 32'h0001_0004;
        addr[1] = 32'h3000_0000;
        rdy_s   = 6'b000010;
        wd      = 1'b0;
        apply_inputs();

        // reset held with both masters requesting
        repeat (3) begin
            @(negedge clk);
            check_all_zero("reset");
        end
        @(posedge clk);
        #1 rst = 1'b1;

        // first IDLE cycle grants M1; its S1 address goes out next cycle
        step();
        drive_check();
        check("t2_awvalid_s", 32'(bus.awvalid_s), 32'h02);
        check("t2_awready_m", 32'(bus.awready_m), 32'h1);
        check("t2_awaddr_s", bus.awaddr_s, 32'h0001_0004);
        commit();
        drive_check();
        check("t2_w_sel_valid", 32'(bus.w_sel_valid), 32'h1);
        check("t2_w_sel_master", 32'(bus.w_sel_master), 32'h0);
        check("t2_w_sel_slave", 32'(bus.w_sel_slave), 32'h1);
        commit();
        // M2 to the default slave
        drive_check();
        check("t5_awvalid_s", 32'(bus.awvalid_s), 32'h0);
        check("t5_awready_m", 32'(bus.awready_m), 32'h2);
        commit();
        wd = 1'b1;
        step();
        wd = 1'b0;
        drive_check();
        check("t5_w_sel_master", 32'(bus.w_sel_master), 32'h1);
        check("t5_w_sel_slave", 32'(bus.w_sel_slave), 32'h7);
        commit();
        wd = 1'b1;
        step();

        // both masters request continuously
        rdy_s   = 6'h3F;
        addr[0] = 32'h0002_0010;
        addr[1] = 32'h0002_0020;
        for (int k = 0; k < 4; k++) begin
            req = 2'b11;
            step();
            drive_check();
`ifdef AW_SCHED_FIXED_PRIO_EN
            check("t3_grant", 32'(bus.awready_m), 32'h1);
`else
            check("t3_grant", 32'(bus.awready_m), (k % 2 == 0) ? 32'h1 : 32'h2);
`endif
            commit();
        end
        req = 2'b00;
        repeat (4) step();

        // fill the order FIFO with no w_done
        wd = 1'b0;
        for (int c = 0; c < 12; c++) begin
            for (int i = 0; i < 2; i++)
                if (!req[i]) begin
                    req[i]  = 1'b1;
                    addr[i] = 32'h0000_0100 + 32'(i);
                end
            step();
        end
        repeat (3) begin
            drive_check();
            check("t4_stall_awready_m", 32'(bus.awready_m), 32'h0);
            check("t4_stall_awvalid_s", 32'(bus.awvalid_s), 32'h0);
            check("t4_full_valid", 32'(bus.w_sel_valid), 32'h1);
            commit();
        end
        wd = 1'b1;
        step();
        wd = 1'b0;
        step();
        drive_check();
        check("t4_fifth_awvalid_s", 32'(bus.awvalid_s), 32'h01);
        check("t4_fifth_accepted", 32'(bus.awready_m != 2'b00), 32'h1);
        commit();
        req = 2'b00;
        wd  = 1'b1;
        repeat (8) step();

        // count=2 and a pop coinciding with a push
        wd = 1'b0;
        req = 2'b01; addr[0] = 32'h1000_0000;
        repeat (2) step();
        req = 2'b10; addr[1] = 32'h1001_0000;
        repeat (2) step();
        req = 2'b01; addr[0] = 32'h2000_0000;
        step();
        wd = 1'b1;
        step();
        wd = 1'b0;
        drive_check();
        check("t6_head_master", 32'(bus.w_sel_master), 32'h1);
        check("t6_head_slave", 32'(bus.w_sel_slave), 32'h4);
        commit();
        wd = 1'b1;
        drive_check();
        commit();
        drive_check();
        check("t6_last_valid", 32'(bus.w_sel_valid), 32'h1);
        check("t6_last_slave", 32'(bus.w_sel_slave), 32'h5);
        commit();
        drive_check();
        check("t6_empty", 32'(bus.w_sel_valid), 32'h0);
        commit();

        // randomized traffic with a reset in the middle
        for (int c = 0; c < 3000; c++) begin
            p_req  = (c < 1000) ? 60 : 90;
            p_done = ((c / 250) % 2 == 1) ? 10 : 50;
            for (int i = 0; i < 2; i++)
                if (!req[i] && $urandom_range(0, 99) < p_req) begin
                    req[i]  = 1'b1;
                    addr[i] = rand_addr();
                end
            rdy_s = 6'($urandom);
            wd    = ($urandom_range(0, 99) < p_done);
            if (c == 1500) do_reset();
            step();
        end

        // drain: no new requests, every burst completes
        rdy_s = 6'h3F;
        wd    = 1'b1;
        repeat (16) step();
        drive_check();
        check("drain_empty", 32'(bus.w_sel_valid), 32'h0);
        commit();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
